// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: synchronous instruction store with fetch handshake, program-load port and range faults.
// Define INSTR_FETCH_MEM_PREFETCH_EN to add a one-entry sequential prefetch buffer.
module instr_fetch_mem #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(16'h0000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err,
    input  logic              fetch_ack,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] arr_q, instr_q, pf_word;
    logic err_q, src_pf_q, accept, addr_oor, hit, pf_rd_en, rd_en;
    logic [IDX_W-1:0] pf_idx;
    assign fetch_ready = state_q == IDLE && !load_we;
    assign accept      = fetch_req && fetch_ready;
    assign addr_oor    = {1'b0, addr_q} >= DEPTH_X;
    assign fetch_valid = state_q == OUT;
    assign fetch_instr = instr_q;
    assign fetch_err   = err_q;
    // single read port: the fetch owns it in ADDR, the prefetcher borrows it while idle
    assign rd_en = state_q == ADDR ? !addr_oor : pf_rd_en;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (hit ? DATA : ADDR) : IDLE;
            ADDR:    state_d = DATA;
            DATA:    state_d = OUT;
            OUT:     state_d = fetch_ack ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (load_we && {1'b0, load_addr} < DEPTH_X) mem[load_addr[IDX_W-1:0]] <= load_data;
        if (rd_en) arr_q <= mem[state_q == ADDR ? addr_q[IDX_W-1:0] : pf_idx];
        if (accept) begin
            addr_q   <= fetch_addr;
            src_pf_q <= hit;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DATA) begin
                instr_q <= src_pf_q ? pf_word : addr_oor ? NOP_WORD : arr_q;
                err_q   <= !src_pf_q && addr_oor;
            end
        end
    end
`ifdef INSTR_FETCH_MEM_PREFETCH_EN
    logic [ADDR_W-1:0] pf_addr_q;
    logic [DATA_W-1:0] pf_data_q;
    logic [ADDR_W:0]   next_x;
    logic pf_pend_q, pf_rd_q, pf_valid_q, pf_start, pf_kill;
    // range check on the unwrapped successor so the top address never prefetches 0
    assign next_x   = {1'b0, addr_q} + 1'b1;
    assign pf_start = state_q == OUT && fetch_ack && !err_q && next_x < DEPTH_X &&
                      !(load_we && load_addr == next_x[ADDR_W-1:0]);
    assign pf_kill  = load_we && load_addr == pf_addr_q;
    assign hit      = pf_valid_q && fetch_addr == pf_addr_q;
    assign pf_rd_en = pf_pend_q;
    assign pf_idx   = pf_addr_q[IDX_W-1:0];
    assign pf_word  = pf_data_q;
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            pf_pend_q  <= 1'b0;
            pf_rd_q    <= 1'b0;
            pf_valid_q <= 1'b0;
        end else begin
            pf_pend_q  <= pf_start;
            pf_rd_q    <= pf_pend_q && !pf_kill;
            pf_valid_q <= (pf_valid_q || pf_rd_q) && !pf_kill;
        end
        if (pf_start) pf_addr_q <= next_x[ADDR_W-1:0];
        if (pf_rd_q) pf_data_q <= arr_q;
    end
`else
    assign hit      = 1'b0;
    assign pf_rd_en = 1'b0;
    assign pf_idx   = addr_q[IDX_W-1:0];
    assign pf_word  = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: randomized scoreboard bench for instr_fetch_mem against a word-array reference model.
module tb_instr_fetch_mem;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int DEPTH = 256;
    typedef struct {
        logic [DW-1:0] instr;
        logic          err;
        int            lat;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1, fetch_req = 1'b0, fetch_ack = 1'b0, load_we = 1'b0;
    logic [AW-1:0] fetch_addr = '0, load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic [DW-1:0] fetch_instr;
    logic fetch_ready, fetch_valid, fetch_err;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];
    exp_t cur;
    logic [DW-1:0] ref_mem [DEPTH];
    int tests = 0, fails = 0, cyc = 0, acc_cyc = 0, pf_addr = -1, ack_edge = -100;

    instr_fetch_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NOP_WORD(16'h0000)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_err(fetch_err), .fetch_ack(fetch_ack), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset && fetch_req && fetch_ready) acc_cyc = cyc;
    end

    always @(negedge clk) begin
        if (fetch_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got instr %0h with nothing outstanding", fetch_instr);
            end else begin
                cur = exp_q.pop_front();
                chk("instr", fetch_instr, cur.instr);
                chk("err", fetch_err, cur.err);
                chk("latency", cyc - acc_cyc, cur.lat);
            end
        end else if (fetch_valid) begin
            chk("hold_instr", fetch_instr, cur.instr);
            chk("hold_err", fetch_err, cur.err);
        end
        prev_valid = fetch_valid;
    end

    function automatic void note_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (int'(a) < DEPTH) ref_mem[a[7:0]] = d;
        if (int'(a) == pf_addr) pf_addr = -1;
    endfunction

    task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_we = 1'b1;
        load_addr = a;
        load_data = d;
        note_load(a, d);
        @(negedge clk);
        load_we = 1'b0;
    endtask

    // mode: 0 plain, 1 same-cycle load, 2 load to in-flight address, 3 reset mid-fetch, 4 extra requests while busy
    task automatic fetch(input logic [AW-1:0] a, input int hold, input int mode, input logic [DW-1:0] d);
        exp_t x;
        int n;
        fetch_req = 1'b1;
        fetch_addr = a;
        if (mode == 1) begin
            load_we = 1'b1;
            load_addr = a;
            load_data = d;
            #1 chk("ready_low_on_load", fetch_ready, 0);
            note_load(a, d);
            @(negedge clk);
            load_we = 1'b0;
        end
        #1 chk("ready_before_accept", fetch_ready, 1);
        x.err = int'(a) >= DEPTH;
        x.instr = x.err ? DW'(0) : ref_mem[a[7:0]];
        x.lat = 2;
`ifdef INSTR_FETCH_MEM_PREFETCH_EN
        if (pf_addr == int'(a) && cyc + 1 >= ack_edge + 3) x.lat = 1;
`endif
        pf_addr = -1;
        exp_q.push_back(x);
        @(negedge clk);
        fetch_req = mode == 4;
        fetch_addr = a ^ 16'h0001;
        if (mode == 2) do_load(a, d);
        if (mode == 3) begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("rst_mid_valid", fetch_valid, 0);
            chk("rst_mid_ready", fetch_ready, 1);
            chk("rst_mid_instr", fetch_instr, 0);
            void'(exp_q.pop_back());
            return;
        end
        n = 0;
        while (!fetch_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        fetch_req = 1'b0;
        if (!fetch_valid) begin
            tests++;
            fails++;
            $display("FAIL valid_timeout: addr %0h got no fetch_valid within 8 cycles", a);
            exp_q.delete();
            return;
        end
        repeat (hold) @(negedge clk);
        chk("valid_before_ack", fetch_valid, 1);
        fetch_ack = 1'b1;
        ack_edge = cyc + 1;
        @(negedge clk);
        fetch_ack = 1'b0;
        pf_addr = (!x.err && int'(a) + 1 < DEPTH) ? int'(a) + 1 : -1;
        chk("valid_after_ack", fetch_valid, 0);
        chk("ready_after_ack", fetch_ready, 1);
    endtask

    initial begin
        logic [AW-1:0] a, last;
        int op, mode;
        repeat (2) @(negedge clk);
        chk("rst_valid", fetch_valid, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_instr", fetch_instr, 0);
        chk("rst_ready", fetch_ready, 1);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_load(AW'(i), DW'($urandom));
        do_load(16'h0000, 16'h3001);
        do_load(16'h0001, 16'h7202);
        do_load(16'h0002, 16'h1200);
        do_load(16'h0003, 16'h6404);
        fetch(16'h0002, 3, 0, '0);
        fetch(16'h0100, 0, 0, '0);
        do_load(16'h0100, 16'hDEAD);
        fetch(16'h0000, 0, 0, '0);
        fetch(16'h0001, 0, 1, 16'hBEEF);
        fetch(16'h0005, 1, 2, 16'hCAFE);
        fetch(16'h0005, 0, 0, '0);
        fetch(16'h0200, 0, 0, '0);
        fetch(16'h0007, 0, 3, '0);
        fetch(16'h0007, 1, 4, '0);
        fetch(16'h0000, 0, 0, '0);
        repeat (2) @(negedge clk);
        fetch(16'h0001, 0, 0, '0);
        fetch(16'h0000, 0, 0, '0);
        do_load(16'h0001, 16'h5555);
        @(negedge clk);
        fetch(16'h0001, 0, 0, '0);
        fetch(16'h00FF, 0, 0, '0);
        repeat (2) @(negedge clk);
        fetch(16'h0000, 0, 0, '0);
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        chk("idle_ack_ignored", fetch_valid, 0);
        last = 16'h0000;
        for (int i = 0; i < 120; i++) begin
            op = $urandom_range(0, 9);
            if (op < 3) begin
                a = op == 0 ? AW'(last + 1) : AW'($urandom_range(0, 300));
                do_load(a, DW'($urandom));
            end else if (op == 3) begin
                fetch_ack = 1'b1;
                @(negedge clk);
                fetch_ack = 1'b0;
                chk("idle_ack_ignored", fetch_valid, 0);
            end else begin
                a = op < 6 ? AW'(last + 1) : op < 9 ? AW'($urandom_range(0, 255)) : AW'($urandom_range(256, 65535));
                mode = $urandom_range(0, 9);
                mode = mode < 6 ? 0 : mode < 8 ? 2 : mode == 8 ? 4 : 1;
                fetch(a, $urandom_range(0, 2), mode, DW'($urandom));
                last = a;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
